// File: rtl/fft_serializer.sv
// fft_serializer
//   Parallel-to-serial converter for FFT result frames. A FRAME_WIDTH-bit
//   frame is accepted over a valid/ready input handshake, held in a local
//   register, and emitted as WORDS = FRAME_WIDTH/WORD_WIDTH words over a
//   valid/ready output stream. The least significant word goes first.
//   Back-to-back frames stream without a bubble: the next frame can be
//   accepted in the same cycle the last word of the current frame leaves.
//
// Ports
//   clk        system clock, rising-edge active
//   reset      asynchronous active-high reset
//   in_valid   in_frame carries a frame to load
//   in_ready   serializer can accept a frame this cycle (depends on out_ready)
//   in_frame   parallel input frame
//   out_ready  downstream accepts out_word this cycle
//   out_valid  out_word is valid
//   out_word   current serial word
//   out_last   high with the final word of a frame
module fft_serializer #(
  parameter int WORD_WIDTH  = 16,
  parameter int FRAME_WIDTH = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FRAME_WIDTH-1:0] in_frame,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [WORD_WIDTH-1:0]  out_word,
  output logic                   out_last
);

  localparam int WORDS = FRAME_WIDTH / WORD_WIDTH;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

  // The frame must split into a whole number of words, and into at least two.
  generate
    if ((FRAME_WIDTH % WORD_WIDTH) != 0 || WORDS < 2) begin : g_bad_params
      $error("fft_serializer: FRAME_WIDTH must be a multiple of WORD_WIDTH with at least 2 words");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [FRAME_WIDTH-1:0] hold_q,  hold_d;

  logic inXfer;
  logic outXfer;
  logic isLast;

  // Slice the holding register into words so the output is a plain mux
  // indexed by the word counter.
  logic [WORD_WIDTH-1:0] wordSel [WORDS];

  for (genvar g = 0; g < WORDS; g++) begin : g_words
    assign wordSel[g] = hold_q[g*WORD_WIDTH +: WORD_WIDTH];
  end

  // Outputs come only from registered state; out_ready never reaches them.
  assign isLast    = (count_q == LAST_IDX);
  assign out_valid = (state_q == SEND);
  assign out_last  = (state_q == SEND) && isLast;
  assign out_word  = (state_q == SEND) ? wordSel[count_q] : '0;

  // Ready to load when idle, or when the final word is leaving this very
  // cycle, which is what allows gap-free back-to-back frames.
  assign in_ready = (state_q == IDLE) || (isLast && out_ready);

  assign inXfer  = in_valid && in_ready;
  assign outXfer = out_valid && out_ready;

  // State, counter and holding register update. A stalled output simply
  // keeps everything as it is.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic. In SEND, the last-word transfer either reloads a new
  // frame (staying in SEND) or returns to IDLE.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (inXfer) begin
          hold_d  = in_frame;
          count_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (outXfer) begin
          if (!isLast) begin
            count_d = count_q + CW'(1);
          end else if (inXfer) begin
            hold_d  = in_frame;
            count_d = '0;
          end else begin
            count_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

endmodule

// File: doc/fft_serializer.md
Name: fft_serializer

Overview:
- Parallel-to-serial converter: the transmit-side counterpart of the 16-to-256 deserializer.
- Accepts one 256-bit FFT result frame and emits it as sixteen 16-bit words over a valid/ready stream.
- Sits between the 8-point FFT core output (8 complex points, 16-bit re/im) and the narrow output bus.
- Supports back-pressure and back-to-back frames with no idle cycle between them.

Parameters:
- WORD_WIDTH, 16, width of each serial output word.
- FRAME_WIDTH, 256, width of the parallel input frame. Must be an integer multiple of WORD_WIDTH, with WORDS = FRAME_WIDTH/WORD_WIDTH >= 2. Elaboration fails otherwise.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_frame holds a frame to load.
- in_ready  output  1  serializer can accept a frame this cycle.
- in_frame  input  FRAME_WIDTH  parallel frame.
- out_ready  input  1  downstream accepts out_word this cycle.
- out_valid  output  1  out_word is valid.
- out_word  output  WORD_WIDTH  current serial word.
- out_last  output  1  high with the final word of a frame.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - Any partial frame is discarded and never resumed.
  - State=IDLE, word counter=0, holding register=0.
  - out_valid=0, out_last=0, out_word=0.
  - in_ready=1 once reset deasserts.
- States: IDLE and SEND.
- Handshakes:
  - Input transfer = in_valid && in_ready at a rising edge.
  - Output transfer = out_valid && out_ready at a rising edge.
- in_ready (combinational):
  - 1 in IDLE.
  - In SEND: 1 only when counter==WORDS-1 && out_ready (last word leaving this cycle); 0 otherwise.
  - in_ready therefore depends combinationally on out_ready. There is no path from in_valid to in_ready.
- IDLE:
  - On input transfer: latch in_frame, counter=0, go to SEND.
  - out_valid becomes 1 in the next cycle (1-cycle latency from accept to first word).
- SEND:
  - out_valid=1.
  - out_word = holding register bits [(counter+1)*WORD_WIDTH-1 : counter*WORD_WIDTH]. Word 0 is in_frame[WORD_WIDTH-1:0]: LSB word first, matching the deserializer's fill order.
  - out_last = (counter==WORDS-1).
  - Output transfer with counter<WORDS-1: counter increments.
  - Output transfer with counter==WORDS-1, no input transfer: go to IDLE, counter=0, out_valid=0 next cycle.
  - Output transfer with counter==WORDS-1 and simultaneous input transfer: reload holding register, counter=0, stay in SEND. Next frame's word 0 appears the very next cycle, so there is no bubble.
- Stall: while out_valid && !out_ready, out_word, out_last and counter hold stable. Downstream may stall indefinitely.
- in_frame is sampled only on an input transfer. Changes at any other time have no effect.
- in_valid while in_ready=0 is ignored. The source must hold the frame until accepted.
- Counter width: clog2(WORDS). It never exceeds WORDS-1 (no wrap-around beyond the frame).
- Throughput: one word per cycle when out_ready is held high; a frame occupies exactly WORDS cycles.
- Registered outputs: out_valid, out_word, out_last derive only from state, counter and holding register; no combinational path from out_ready.

Test Plan:
- Reset asserted, then released with in_valid=0 -> out_valid=0, out_last=0, out_word=0, in_ready=1; stays idle indefinitely.
- Frame with word k = 16'h1000+k (k=0..15), out_ready=1 -> out_word 1000,1001,...,100F on 16 consecutive cycles starting the cycle after accept; out_last high only with 100F; then out_valid=0, in_ready=1.
- Same frame, out_ready toggled 1,0,0,1 repeatedly -> each word held stable while out_ready=0; no word duplicated or skipped; 16 transfers total; out_last only on word 15.
- Two frames A (words 16'hA000+k) and B (16'hB000+k), in_valid held, out_ready=1 -> in_ready pulses with A's word 15; B's word 0 follows A's word 15 with no gap; 32 contiguous valid cycles.
- Reset pulsed asynchronously (between edges) while word 7 is presented -> out_valid drops immediately; after release, a new frame 16'hC000+k streams from C000, with no residue of the aborted frame.
- in_valid with frame D while A is mid-frame (counter=5) -> D ignored until A's last-word transfer; D is accepted only if still presented then; A's output is uncorrupted.
